// File: rtl/router_pkg.sv
// Shared router definitions: flit layout, flit-type codes and the output-port FSM states.
package router_pkg;

    localparam int FLIT_W = 10;
    localparam int NPORT  = 4;

    localparam logic [1:0] FT_IDLE = 2'b00;
    localparam logic [1:0] FT_TAIL = 2'b01;
    localparam logic [1:0] FT_HEAD = 2'b10;
    localparam logic [1:0] FT_BODY = 2'b11;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0] ftype;
        logic [7:0] payload;
    } flit_t;

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin pick: first set request scanning upward from ptr+1, wrapping.
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] w_cand;

    // Scan from the farthest candidate back to the nearest so the nearest set bit wins.
    always_comb begin
        idx    = '0;
        w_cand = '0;
        for (int unsigned k = 4; k >= 1; k--) begin
            w_cand = ptr + 2'(k);
            if (req[w_cand]) idx = w_cand;
        end
    end

    assign any = |req;

endmodule

// File: rtl/outport_arb.sv
// One router output port: round-robin packet-granular arbitration with a registered flit output.
module outport_arb
    import router_pkg::*;
#(
    parameter int NPORT  = router_pkg::NPORT,
    parameter int FLIT_W = router_pkg::FLIT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NPORT-1:0]              req,
    input  logic [NPORT-1:0][FLIT_W-1:0]  pkti,
    input  logic                          out_ready,
    output logic [NPORT-1:0]              grant,
    output logic [FLIT_W-1:0]             pkto,
    output logic                          busy
);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_ptr;
    logic [1:0]         r_lock;
    logic [FLIT_W-1:0]  r_pkto;

    logic [1:0]         w_idx;
    logic               w_any;
    flit_t              w_flit;
    logic               w_take;
    logic               w_tail;

    rr_arb4 u_rr (
        .req (req),
        .ptr (r_ptr),
        .idx (w_idx),
        .any (w_any)
    );

    assign w_flit = flit_t'(pkti[r_lock]);
    assign w_take = (r_state == XFER) && out_ready && (w_flit.ftype != FT_IDLE);
    assign w_tail = w_take && (w_flit.ftype == FT_TAIL);

    always_comb begin
        w_next = r_state;
        grant  = '0;
        case (r_state)
            ARB: begin
                if (w_any) w_next = XFER;
            end
            XFER: begin
                grant[r_lock] = w_take;
                if (w_tail) w_next = ARB;
            end
            default: w_next = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB;
            r_ptr   <= 2'd3;
            r_lock  <= '0;
            r_pkto  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ARB && w_any) r_lock <= w_idx;
            r_pkto <= w_take ? pkti[r_lock] : '0;
            // The just-served input becomes the scan origin, so it gets lowest priority next.
            if (w_tail) r_ptr <= r_lock;
        end
    end

    assign pkto = r_pkto;
    assign busy = (r_state == XFER);

endmodule

// File: doc/outport_arb.md
# outport_arb

One output port of the 4x4 router's switch stage: collects per-input one-hot requests produced by the request decoders for this port, picks one input by round-robin, and holds that grant for the whole packet, until its tail flit has passed. Forwards the granted input's flits, one per cycle, onto a registered 10-bit output link. Generates a pop strobe back to the granted input buffer. Four instances, one per output port, sit between the per-input request decoders and the output links.

## Interface
- NPORT, 4: number of router inputs competing for this output; fixed at 4 in this revision.
- FLIT_W, 10: flit width; [9:8] = flit type, [7:0] = payload (header: [1:0] = destination port).

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NPORT  bit i = input i's decoder requests this output; meaningful only while input i presents a HEAD flit.
- pkti  in  NPORT x FLIT_W  head-of-queue flit of each input buffer.
- out_ready  in  1  downstream link accepts a flit this cycle.
- grant  out  NPORT  one-hot pop strobe to the input buffer whose flit is taken this cycle; combinational.
- pkto  out  FLIT_W  registered output flit; type IDLE (all zero) when no flit is sent.
- busy  out  1  high while a packet holds this output.

## Operation
- Flit types (shared package): IDLE 2'b00, TAIL 2'b01, HEAD 2'b10, BODY 2'b11. A packet is one HEAD, zero or more BODY, and one TAIL; the minimum packet is 2 flits.
- State machine: ARB, XFER.
- ARB: if req != 0, select the first set bit scanning from ptr+1 upward, mod 4. Register it in lock and go to XFER. No flit is forwarded in the ARB cycle and grant = 0.
- XFER: grant[lock] = out_ready && pkti[lock][9:8] != IDLE; all other grant bits are 0. When grant[lock] is high, pkto <= pkti[lock]; otherwise pkto <= 0.
- XFER exit: when the taken flit is a TAIL, set ptr <= lock and next state ARB. The just-served input then has lowest priority.
- req is ignored in XFER; competing heads wait in their buffers.
- An IDLE flit on pkti[lock] mid-packet is a bubble: no grant, lock held, no timeout.
- busy = (state == XFER).

## Timing
- Reset values: state ARB, ptr = 3 (input 0 wins first), lock = 0, pkto = 0, grant = 0, busy = 0.
- Arbitration latency: 1 cycle, from req seen in ARB to XFER.
- Forwarding: a flit granted in cycle t appears on pkto in cycle t+1 for exactly one cycle. Throughput is 1 flit per cycle while out_ready is high and the locked input has flits.
- out_ready low: no grant; pkto is IDLE the next cycle; the locked input keeps its flit.
- TAIL taken in cycle t: ARB in t+1, new lock in t+2, next packet's HEAD on pkto no earlier than t+3. This gives 1 bubble cycle between back-to-back packets.
- Reset asserted mid-packet: all state returns to reset values on that edge. The partial packet is abandoned; recovery is the upstream's responsibility.

## Structure
- Package router_pkg: FLIT_W, NPORT, flit-type localparams (FT_IDLE, FT_TAIL, FT_HEAD, FT_BODY), the state enum, and the flit_t typedef (type and payload fields).
- Sub-module rr_arb4: combinational round-robin pick. Inputs: req[3:0] and ptr[1:0]. Outputs: idx[1:0] and any. Reused by later credit-based variants.

## Test plan
- Reset, then req=4'b0001 with pkti[0] = HEAD, BODY, TAIL and out_ready=1. Required: busy rises next cycle; grant[0] pulses 3 consecutive cycles; pkto shows the 3 flits 1 cycle after each grant, then 0.
- req=4'b1111 held, every input sending 2-flit packets. Required: service order 0,1,2,3,0; each TAIL is followed by exactly 1 ARB cycle.
- out_ready low for 2 cycles mid-packet on input 2. Required: grant=0 and pkto=0 for those cycles; the BODY flit appears after out_ready returns; lock stays 2.
- During input 1's packet, input 3 raises req. Required: no grant[3] until input 1's TAIL passes; then input 3 wins, even if input 0 also requests (ptr=1 gives the scan order 2,3,0).
- rst_n low for 1 cycle after HEAD of input 0 is forwarded. Required: next cycle busy=0, pkto=0, grant=0; with req=4'b0011 after reset, input 0 is granted first.
